pll_config_sequencer: RTL and testbench
=======================================

// Module: pll_config_sequencer
// PURPOSE
//  Upstream stage of the digital PLL: owns the PLL's reset_n, enable, dco, div and ext_trim inputs.
//  - Accepts configuration requests over a valid/ready handshake.
//  - Sequences each request as: hold the PLL in reset, apply the new settings, release reset, wait
//    a settle time, then report ready.
//  - Runs on the core clock (derived from the external oscillator); the controller never sees
//    div/dco changes while it is running.
// PARAMETERS
//  HOLD_CYCLES    4     cycles pll_reset_n is held low after an accepted config (>=1)
//  SETTLE_CYCLES  1024  cycles from pll_reset_n release to pll_ready (>=1)
//  DIV_RST        5'd4  pll_div value after reset
// PORTS
//  clock         in   1   core clock
//  reset         in   1   synchronous, active-high reset
//  cfg_valid     in   1   config request valid
//  cfg_ready     out  1   sequencer can accept a request (state OFF or LOCKED)
//  cfg_enable    in   1   requested PLL enable
//  cfg_dco       in   1   requested DCO mode
//  cfg_div       in   5   requested feedback divide ratio
//  cfg_trim      in   26  requested external trim (DCO mode)
//  cfg_err       out  1   sticky: last request was illegal and was dropped
//  pll_reset_n   out  1   to PLL reset_n
//  pll_enable    out  1   to PLL enable
//  pll_dco       out  1   to PLL dco
//  pll_div       out  5   to PLL div
//  pll_ext_trim  out  26  to PLL ext_trim
//  pll_ready     out  1   PLL configured and settled
// BEHAVIOUR
//  - Reset state: OFF. Output values:
//    pll_reset_n=0, pll_enable=0, pll_dco=0, pll_div=DIV_RST, pll_ext_trim=0,
//    pll_ready=0, cfg_err=0, cfg_ready=1.
//    Reset wins over any simultaneous cfg_valid.
//  - States: OFF, HOLD, SETTLE, LOCKED. All outputs are registered; cfg_ready is decoded from state.
//    A request is accepted on an edge with cfg_valid & cfg_ready; requests in HOLD/SETTLE are ignored,
//    and the requester holds cfg_valid until accepted.
//  - Illegal request: cfg_enable=1, cfg_dco=0, cfg_div<2. Next edge: cfg_err=1, request dropped,
//    state and all pll_* outputs unchanged. Any legal accept clears cfg_err.
//  - Disable (accepted with cfg_enable=0):
//    - Next edge -> OFF: pll_enable=0, pll_reset_n=0, pll_ready=0.
//    - pll_div, pll_dco and pll_ext_trim keep their values.
//  - Full sequence (accepted with cfg_enable=1, not fast path), accept edge = E0:
//    - E0+1: HOLD. pll_enable=1, pll_reset_n=0, pll_ready=0; pll_dco, pll_div and pll_ext_trim take
//      the request values.
//    - E0+1+HOLD_CYCLES: SETTLE. pll_reset_n=1.
//    - E0+1+HOLD_CYCLES+SETTLE_CYCLES: LOCKED. pll_ready=1.
//  - DCO fast path: in LOCKED with pll_dco=1, an accept with cfg_enable=1 and cfg_dco=1 does the
//    following on the next edge:
//    - pll_ext_trim <= cfg_trim; pll_div <= cfg_div.
//    - State stays LOCKED; pll_ready and pll_reset_n stay 1.
//    - No sequence is run, since the controller is held in reset in DCO mode.
//  - Any dco change from LOCKED runs the full sequence.
//  - Counter: one down-counter, width $clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1). It loads on state
//    entry and transitions at 0; it never wraps.
//  - Reset mid-HOLD or mid-SETTLE: next edge gives the reset values; no partial sequence resumes.
// STRUCTURE
//  - Package pll_seq_pkg holds:
//    - state enum {OFF, HOLD, SETTLE, LOCKED};
//    - PLL_DIV_W=5, PLL_TRIM_W=26, PLL_DIV_MIN=2.
//  - One sub-module, pll_seq_timer: loadable down-counter with a zero flag, shared by HOLD and SETTLE.
// TESTING (HOLD_CYCLES=4, SETTLE_CYCLES=16)
//  - Reset: assert reset 2 cycles -> all outputs at reset values, cfg_ready=1, cfg_err=0.
//  - FLL bring-up: accept {en=1, dco=0, div=8} at E0 ->
//    - E0+1: pll_enable=1, pll_div=8, pll_reset_n=0;
//    - E0+5: pll_reset_n=1;
//    - E0+21: pll_ready=1;
//    - cfg_ready=0 during E0+1..E0+20.
//  - DCO trim: in LOCKED with dco=1, accept trim 26'h0155AAA -> next edge pll_ext_trim=26'h0155AAA;
//    pll_ready and pll_reset_n stay 1 throughout.
//  - Illegal: accept {en=1, dco=0, div=1} -> cfg_err=1 and outputs unchanged; a following legal
//    {div=6} clears cfg_err and runs the full sequence.
//  - Disable: from LOCKED accept en=0 -> next edge pll_enable=0, pll_reset_n=0, pll_ready=0,
//    pll_div retained.
//  - Reset mid-SETTLE (E0+10) with cfg_valid held high -> next edge gives the reset values;
//    the held request is then accepted and runs a fresh full sequence.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL configuration sequencer.
package pll_seq_pkg;

  localparam int unsigned PLL_DIV_W  = 5;
  localparam int unsigned PLL_TRIM_W = 26;
  localparam logic [PLL_DIV_W-1:0] PLL_DIV_MIN = 5'd2;

  typedef enum logic [1:0] {
    StOff,
    StHold,
    StSettle,
    StLocked
  } pll_seq_state_e;

endpackage

// File: rtl/pll_seq_timer.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module pll_seq_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             zero
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pll_config_sequencer.sv
// Sequences PLL configuration requests: reset hold, apply settings, release, settle, ready.
module pll_config_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned           HOLD_CYCLES   = 4,
  parameter int unsigned           SETTLE_CYCLES = 1024,
  parameter logic [PLL_DIV_W-1:0]  DIV_RST       = 5'd4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_enable,
  input  logic                  cfg_dco,
  input  logic [PLL_DIV_W-1:0]  cfg_div,
  input  logic [PLL_TRIM_W-1:0] cfg_trim,
  output logic                  cfg_err,
  output logic                  pll_reset_n,
  output logic                  pll_enable,
  output logic                  pll_dco,
  output logic [PLL_DIV_W-1:0]  pll_div,
  output logic [PLL_TRIM_W-1:0] pll_ext_trim,
  output logic                  pll_ready
);

  localparam int unsigned CntMax = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  pll_seq_state_e state_q, state_d;

  logic                  err_q, err_d;
  logic                  rst_n_q, rst_n_d;
  logic                  enable_q, enable_d;
  logic                  dco_q, dco_d;
  logic [PLL_DIV_W-1:0]  div_q, div_d;
  logic [PLL_TRIM_W-1:0] trim_q, trim_d;
  logic                  ready_q, ready_d;

  logic            timer_load;
  logic [CntW-1:0] timer_value;
  logic            timer_zero;

  logic accept;
  logic illegal;
  logic fast_path;

  assign cfg_ready = (state_q == StOff) || (state_q == StLocked);
  assign accept    = cfg_valid && cfg_ready;
  assign illegal   = cfg_enable && !cfg_dco && (cfg_div < PLL_DIV_MIN);
  // Trim/div retune in DCO mode needs no reset: the controller is already held off.
  assign fast_path = (state_q == StLocked) && dco_q && cfg_enable && cfg_dco;

  pll_seq_timer #(
    .Width (CntW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    rst_n_d     = rst_n_q;
    enable_d    = enable_q;
    dco_d       = dco_q;
    div_d       = div_q;
    trim_d      = trim_q;
    ready_d     = ready_q;
    timer_load  = 1'b0;
    timer_value = '0;

    unique case (state_q)
      StOff, StLocked: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            err_d = 1'b0;
            if (!cfg_enable) begin
              state_d  = StOff;
              enable_d = 1'b0;
              rst_n_d  = 1'b0;
              ready_d  = 1'b0;
            end else if (fast_path) begin
              div_d  = cfg_div;
              trim_d = cfg_trim;
            end else begin
              state_d     = StHold;
              enable_d    = 1'b1;
              rst_n_d     = 1'b0;
              ready_d     = 1'b0;
              dco_d       = cfg_dco;
              div_d       = cfg_div;
              trim_d      = cfg_trim;
              timer_load  = 1'b1;
              timer_value = CntW'(HOLD_CYCLES - 1);
            end
          end
        end
      end
      StHold: begin
        if (timer_zero) begin
          state_d     = StSettle;
          rst_n_d     = 1'b1;
          timer_load  = 1'b1;
          timer_value = CntW'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (timer_zero) begin
          state_d = StLocked;
          ready_d = 1'b1;
        end
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StOff;
      err_q    <= 1'b0;
      rst_n_q  <= 1'b0;
      enable_q <= 1'b0;
      dco_q    <= 1'b0;
      div_q    <= DIV_RST;
      trim_q   <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rst_n_q  <= rst_n_d;
      enable_q <= enable_d;
      dco_q    <= dco_d;
      div_q    <= div_d;
      trim_q   <= trim_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_err      = err_q;
  assign pll_reset_n  = rst_n_q;
  assign pll_enable   = enable_q;
  assign pll_dco      = dco_q;
  assign pll_div      = div_q;
  assign pll_ext_trim = trim_q;
  assign pll_ready    = ready_q;

endmodule

// File: tb/tb_pll_config_sequencer.sv
// Directed, table-driven bench for pll_config_sequencer with HOLD=4, SETTLE=16.
module tb_pll_config_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_enable = 1'b0;
  logic        cfg_dco = 1'b0;
  logic [4:0]  cfg_div = '0;
  logic [25:0] cfg_trim = '0;
  logic        cfg_err;
  logic        pll_reset_n;
  logic        pll_enable;
  logic        pll_dco;
  logic [4:0]  pll_div;
  logic [25:0] pll_ext_trim;
  logic        pll_ready;

  int checks = 0;
  int failures = 0;

  pll_config_sequencer #(
    .HOLD_CYCLES   (4),
    .SETTLE_CYCLES (16),
    .DIV_RST       (5'd4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_enable   (cfg_enable),
    .cfg_dco      (cfg_dco),
    .cfg_div      (cfg_div),
    .cfg_trim     (cfg_trim),
    .cfg_err      (cfg_err),
    .pll_reset_n  (pll_reset_n),
    .pll_enable   (pll_enable),
    .pll_dco      (pll_dco),
    .pll_div      (pll_div),
    .pll_ext_trim (pll_ext_trim),
    .pll_ready    (pll_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic        en;
    logic        dco;
    logic [4:0]  div;
    logic [25:0] trim;
    int          ncyc;
    logic        e_rstn;
    logic        e_en;
    logic        e_dco;
    logic [4:0]  e_div;
    logic [25:0] e_trim;
    logic        e_ready;
    logic        e_err;
    logic        e_crdy;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic rstn, input logic en, input logic dco,
                         input logic [4:0] div, input logic [25:0] trim, input logic ready,
                         input logic err, input logic crdy);
    chk({name, ".pll_reset_n"}, 32'(pll_reset_n), 32'(rstn));
    chk({name, ".pll_enable"}, 32'(pll_enable), 32'(en));
    chk({name, ".pll_dco"}, 32'(pll_dco), 32'(dco));
    chk({name, ".pll_div"}, 32'(pll_div), 32'(div));
    chk({name, ".pll_ext_trim"}, 32'(pll_ext_trim), 32'(trim));
    chk({name, ".pll_ready"}, 32'(pll_ready), 32'(ready));
    chk({name, ".cfg_err"}, 32'(cfg_err), 32'(err));
    chk({name, ".cfg_ready"}, 32'(cfg_ready), 32'(crdy));
  endtask

  initial begin
    // name, rst, valid, en, dco, div, trim, ncyc | rstn, en, dco, div, trim, ready, err, crdy
    vecs.push_back('{"reset",      1, 0, 0, 0, 5'd0,  26'h0,       2,  0, 0, 0, 5'd4,  26'h0,       0, 0, 1});
    vecs.push_back('{"fll_e1",     0, 1, 1, 0, 5'd8,  26'h0,       1,  0, 1, 0, 5'd8,  26'h0,       0, 0, 0});
    vecs.push_back('{"fll_e4",     0, 0, 0, 0, 5'd0,  26'h0,       3,  0, 1, 0, 5'd8,  26'h0,       0, 0, 0});
    vecs.push_back('{"fll_e5",     0, 0, 0, 0, 5'd0,  26'h0,       1,  1, 1, 0, 5'd8,  26'h0,       0, 0, 0});
    vecs.push_back('{"fll_e20",    0, 0, 0, 0, 5'd0,  26'h0,       15, 1, 1, 0, 5'd8,  26'h0,       0, 0, 0});
    vecs.push_back('{"fll_e21",    0, 0, 0, 0, 5'd0,  26'h0,       1,  1, 1, 0, 5'd8,  26'h0,       1, 0, 1});
    vecs.push_back('{"to_dco",     0, 1, 1, 1, 5'd8,  26'h0000123, 1,  0, 1, 1, 5'd8,  26'h0000123, 0, 0, 0});
    vecs.push_back('{"dco_lock",   0, 0, 0, 0, 5'd0,  26'h0,       20, 1, 1, 1, 5'd8,  26'h0000123, 1, 0, 1});
    vecs.push_back('{"dco_trim",   0, 1, 1, 1, 5'd10, 26'h0155AAA, 1,  1, 1, 1, 5'd10, 26'h0155AAA, 1, 0, 1});
    vecs.push_back('{"trim_hold",  0, 0, 0, 0, 5'd0,  26'h0,       1,  1, 1, 1, 5'd10, 26'h0155AAA, 1, 0, 1});
    vecs.push_back('{"illegal",    0, 1, 1, 0, 5'd1,  26'h0,       1,  1, 1, 1, 5'd10, 26'h0155AAA, 1, 1, 1});
    vecs.push_back('{"legal_div6", 0, 1, 1, 0, 5'd6,  26'h0000ABC, 1,  0, 1, 0, 5'd6,  26'h0000ABC, 0, 0, 0});
    vecs.push_back('{"div6_lock",  0, 0, 0, 0, 5'd0,  26'h0,       20, 1, 1, 0, 5'd6,  26'h0000ABC, 1, 0, 1});
    vecs.push_back('{"disable",    0, 1, 0, 0, 5'd3,  26'h5,       1,  0, 0, 0, 5'd6,  26'h0000ABC, 0, 0, 1});
    vecs.push_back('{"from_off",   0, 1, 1, 0, 5'd9,  26'h0,       1,  0, 1, 0, 5'd9,  26'h0,       0, 0, 0});
    vecs.push_back('{"hold_ign",   0, 1, 1, 1, 5'd12, 26'h77,      1,  0, 1, 0, 5'd9,  26'h0,       0, 0, 0});
    vecs.push_back('{"div9_lock",  0, 0, 0, 0, 5'd0,  26'h0,       19, 1, 1, 0, 5'd9,  26'h0,       1, 0, 1});

    #2;
    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      cfg_valid  = vecs[i].valid;
      cfg_enable = vecs[i].en;
      cfg_dco    = vecs[i].dco;
      cfg_div    = vecs[i].div;
      cfg_trim   = vecs[i].trim;
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        step();
        cfg_valid = 1'b0;
      end
      reset = 1'b0;
      chk_all(vecs[i].name, vecs[i].e_rstn, vecs[i].e_en, vecs[i].e_dco, vecs[i].e_div,
              vecs[i].e_trim, vecs[i].e_ready, vecs[i].e_err, vecs[i].e_crdy);
    end

    // Reset mid-SETTLE with the request still held: reset wins, then the request restarts.
    cfg_valid  = 1'b1;
    cfg_enable = 1'b1;
    cfg_dco    = 1'b0;
    cfg_div    = 5'd7;
    cfg_trim   = 26'h55;
    step();
    chk_all("mid_e1", 0, 1, 0, 5'd7, 26'h55, 0, 0, 0);
    for (int c = 0; c < 8; c++) step();
    chk_all("mid_e9", 1, 1, 0, 5'd7, 26'h55, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_all("mid_rst", 0, 0, 0, 5'd4, 26'h0, 0, 0, 1);
    reset = 1'b0;
    step();
    chk_all("restart", 0, 1, 0, 5'd7, 26'h55, 0, 0, 0);
    cfg_valid = 1'b0;
    for (int k = 2; k <= 20; k++) begin
      step();
      chk($sformatf("restart_busy_e%0d.cfg_ready", k), 32'(cfg_ready), 32'd0);
      chk($sformatf("restart_busy_e%0d.pll_reset_n", k), 32'(pll_reset_n), 32'(k >= 5));
      chk($sformatf("restart_busy_e%0d.pll_ready", k), 32'(pll_ready), 32'd0);
    end
    step();
    chk_all("restart_lock", 1, 1, 0, 5'd7, 26'h55, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
